// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the SLC3 memory responder: FSM state codes,
// access opcode, address-region decode and the byte-lane mask helper.
package mem_resp_pkg;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] WAIT   = 3'd1;
  localparam logic [2:0] ACCESS = 3'd2;
  localparam logic [2:0] RESP   = 3'd3;
  localparam logic [2:0] HOLD   = 3'd4;

  typedef enum logic {
    OP_RD,
    OP_WR
  } op_e;

  typedef enum logic [1:0] {
    REG_RAM,
    REG_IO,
    REG_NONE
  } region_e;

  localparam logic [15:0] DEFAULT_IO_ADDR = 16'hFFFF;

  // lanes[1] enables bits [15:8], lanes[0] enables bits [7:0]
  function automatic logic [15:0] lane_mask(input logic [1:0] lanes);
    return {{8{lanes[1]}}, {8{lanes[0]}}};
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// SRAM-style CPU bus between the SLC3 core (master) and the memory responder (slave).
interface mem_responder_if;
  logic        Mem_CE;
  logic        Mem_OE;
  logic        Mem_WE;
  logic        Mem_UB;
  logic        Mem_LB;
  logic [19:0] ADDR;
  logic [15:0] Data_from_cpu;
  logic [15:0] Data_to_cpu;
  logic        Mem_Rdy;

  modport master (
    output Mem_CE, Mem_OE, Mem_WE, Mem_UB, Mem_LB, ADDR, Data_from_cpu,
    input  Data_to_cpu, Mem_Rdy
  );

  modport slave (
    input  Mem_CE, Mem_OE, Mem_WE, Mem_UB, Mem_LB, ADDR, Data_from_cpu,
    output Data_to_cpu, Mem_Rdy
  );
endinterface

// File: rtl/mem_responder_bytelane_ram.sv
// Single-port synchronous 16-bit word RAM with independent byte write enables
// and a registered read port (old data is returned on a same-address write).
module bytelane_ram #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic [1:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [15:0]   wdata,
  output logic [15:0]   rdata
);

  logic [15:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (we[0]) mem[addr][7:0]  <= wdata[7:0];
    if (we[1]) mem[addr][15:8] <= wdata[15:8];
    rdata <= mem[addr];
  end

endmodule

// File: rtl/mem_responder.sv
// SLC3 memory responder: wait-stated RAM plus switch/hex I/O port on the CPU bus.
// Define MEM_STATS_EN to add the saturating Rd_count/Wr_count access counters.
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int          DEPTH_LOG2  = 10,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [15:0] IO_ADDR     = DEFAULT_IO_ADDR
) (
  input  logic             Clk,
  input  logic             Reset,
  mem_responder_if.slave   bus,
  input  logic [15:0]      Switches,
  output logic [15:0]      Hex_out
`ifdef MEM_STATS_EN
  ,
  output logic [15:0]      Rd_count,
  output logic [15:0]      Wr_count
`endif
);

  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  logic [2:0]            state;
  logic [CW-1:0]         wait_cnt;
  op_e                   lat_op;
  region_e               lat_region;
  region_e               region_next;
  logic [DEPTH_LOG2-1:0] lat_addr;
  logic [15:0]           lat_data;
  logic [1:0]            lat_lanes;
  logic [15:0]           sw_meta;
  logic [15:0]           sw_sync;
  logic [15:0]           ram_rdata;
  logic [15:0]           rd_value;
  logic [1:0]            ram_we;
  logic                  rdy;
  logic [15:0]           rd_data;
  logic                  req;
  logic [15:0]           mask;

  assign req  = !bus.Mem_CE && (!bus.Mem_OE || !bus.Mem_WE);
  assign mask = lane_mask(lat_lanes);

  assign bus.Mem_Rdy     = rdy;
  assign bus.Data_to_cpu = rd_data;

  always_comb begin
    region_next = REG_NONE;
    if (bus.ADDR[19:16] == 4'h0 && bus.ADDR[15:0] == IO_ADDR)
      region_next = REG_IO;
    else if (bus.ADDR[19:DEPTH_LOG2] == '0)
      region_next = REG_RAM;
  end

  // Gating with Reset keeps a reset that lands on the ACCESS edge from writing.
  assign ram_we = (Reset && state == ACCESS && lat_op == OP_WR && lat_region == REG_RAM)
                  ? lat_lanes : 2'b00;

  bytelane_ram #(.AW(DEPTH_LOG2)) u_ram (
    .clk   (Clk),
    .we    (ram_we),
    .addr  (lat_addr),
    .wdata (lat_data),
    .rdata (ram_rdata)
  );

  always_comb begin
    rd_value = '0;
    case (lat_region)
      REG_RAM: rd_value = ram_rdata;
      REG_IO:  rd_value = sw_sync;
      default: rd_value = '0;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      rdy        <= 1'b0;
      rd_data    <= '0;
      Hex_out    <= '0;
      sw_meta    <= '0;
      sw_sync    <= '0;
      lat_op     <= OP_RD;
      lat_region <= REG_NONE;
      lat_addr   <= '0;
      lat_data   <= '0;
      lat_lanes  <= '0;
    end else begin
      rdy     <= 1'b0;
      sw_meta <= Switches;
      sw_sync <= sw_meta;
      case (state)
        IDLE: begin
          if (req) begin
            lat_op     <= bus.Mem_WE ? OP_RD : OP_WR;
            lat_region <= region_next;
            lat_addr   <= bus.ADDR[DEPTH_LOG2-1:0];
            lat_data   <= bus.Data_from_cpu;
            lat_lanes  <= {~bus.Mem_UB, ~bus.Mem_LB};
            wait_cnt   <= CW'(WAIT_CYCLES - 1);
            state      <= (WAIT_CYCLES == 0) ? ACCESS : WAIT;
          end
        end
        WAIT: begin
          if (wait_cnt == '0)
            state <= ACCESS;
          else
            wait_cnt <= wait_cnt - CW'(1);
        end
        ACCESS: begin
          if (lat_op == OP_WR && lat_region == REG_IO)
            Hex_out <= (Hex_out & ~mask) | (lat_data & mask);
          state <= RESP;
        end
        RESP: begin
          rdy <= 1'b1;
          if (lat_op == OP_RD)
            rd_data <= rd_value & mask;
          state <= HOLD;
        end
        HOLD: begin
          // Wait for the CPU to drop the request so a held strobe is one access.
          if (bus.Mem_CE || (bus.Mem_OE && bus.Mem_WE))
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MEM_STATS_EN
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      Rd_count <= '0;
      Wr_count <= '0;
    end else if (state == ACCESS && lat_region != REG_NONE) begin
      if (lat_op == OP_RD && Rd_count != 16'hFFFF)
        Rd_count <= Rd_count + 16'd1;
      if (lat_op == OP_WR && Wr_count != 16'hFFFF)
        Wr_count <= Wr_count + 16'd1;
    end
  end
`endif

endmodule
